// File: rtl/i2c_slave_responder.sv
// I2C slave responder: one protocol engine serving one of NUM_BUSSES busses.
// Optional feature macro: I2C_SLAVE_STRETCH_EN (hold SCL low on read underrun).
module i2c_slave_responder #(
    parameter int         NUM_BUSSES = 1,
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         FILT_LEN   = 3,
    localparam int        SEL_W      = (NUM_BUSSES > 1) ? $clog2(NUM_BUSSES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_BUSSES-1:0] scl_i,
    input  logic [NUM_BUSSES-1:0] sda_i,
    output logic [NUM_BUSSES-1:0] scl_o,
    output logic [NUM_BUSSES-1:0] sda_o,
    input  logic [SEL_W-1:0]      bus_sel_i,
    output logic                  busy_o,
    output logic                  wr_valid_o,
    output logic [7:0]            wr_data_o,
    output logic                  rd_req_o,
    input  logic                  rd_valid_i,
    input  logic [7:0]            rd_data_i,
    output logic                  rd_underrun_o
);

    // Read handshake: rd_req_o pulses once per byte and leaves a request pending;
    // the first rd_valid_i seen while it is pending (same cycle or later) is consumed.
    // rd_valid_i with nothing pending is ignored. wr_valid_o is a bare one-cycle pulse.

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
        S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [NUM_BUSSES-1:0] scl_s1, scl_s2, sda_s1, sda_s2, bus_oh;
    logic [SEL_W-1:0]      bus_q, bus_n;
    logic [1:0]            line_sel, line_f, line_fd;   // bit 0 = SCL, bit 1 = SDA
    logic [3:0]            filt_cnt [2];

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, wr_data_n, rx_byte;
    logic       rw, rw_n, sda_drv, sda_drv_n;
    logic       wr_valid_n, rd_req_n, rd_pend, rd_pend_n, rd_underrun_n;
    logic       scl_rise, scl_fall, start_det, stop_det;

    assign bus_oh   = NUM_BUSSES'(1) << bus_q;
    assign line_sel = {|(sda_s2 & bus_oh), |(scl_s2 & bus_oh)};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_s1 <= '1;
            scl_s2 <= '1;
            sda_s1 <= '1;
            sda_s2 <= '1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
        end
    end

    // A new level is accepted only after FILT_LEN consecutive matching samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_f      <= 2'b11;
            line_fd     <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            line_fd <= line_f;
            for (int i = 0; i < 2; i++) begin
                if (line_sel[i] == line_f[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == 4'(FILT_LEN - 1)) begin
                    line_f[i]   <= line_sel[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise  = line_f[0] & ~line_fd[0];
    assign scl_fall  = ~line_f[0] & line_fd[0];
    assign start_det = ~line_f[1] & line_fd[1] & line_f[0] & line_fd[0];
    assign stop_det  = line_f[1] & ~line_fd[1] & line_f[0] & line_fd[0];
    assign rx_byte   = {shift[6:0], line_f[1]};

`ifdef I2C_SLAVE_STRETCH_EN
    logic scl_drv, scl_drv_n;
`endif

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        rw_n          = rw;
        sda_drv_n     = sda_drv;
        wr_valid_n    = 1'b0;
        wr_data_n     = wr_data_o;
        rd_req_n      = 1'b0;
        rd_pend_n     = rd_pend;
        rd_underrun_n = 1'b0;
        bus_n         = bus_q;
        if (stop_det) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            sda_drv_n = 1'b0;
            rd_pend_n = 1'b0;
        end else if (start_det) begin
            state_n   = S_ADDR;
            bit_cnt_n = '0;
            sda_drv_n = 1'b0;
            rd_pend_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: bus_n = bus_sel_i;
                S_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_WR_DATA) begin
                                wr_valid_n = 1'b1;
                                wr_data_n  = rx_byte;
                                state_n    = S_WR_ACK;
                            end else if (rx_byte[7:1] == SLAVE_ADDR) begin
                                rw_n    = rx_byte[0];
                                state_n = S_ADDR_ACK;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall starts the ACK drive, the second one ends it.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_drv) begin
                            sda_drv_n = 1'b1;
                        end else begin
                            sda_drv_n = 1'b0;
                            bit_cnt_n = '0;
                            if (state == S_WR_ACK || !rw) begin
                                state_n = S_WR_DATA;
                            end else begin
                                state_n   = S_RD_LOAD;
                                rd_req_n  = 1'b1;
                                rd_pend_n = 1'b1;
                            end
                        end
                    end
                end
                S_RD_LOAD: begin
`ifndef I2C_SLAVE_STRETCH_EN
                    // Bit 7 must be on SDA before SCL rises; otherwise send 8'hFF.
                    if (scl_rise) begin
                        shift_n       = 8'hFF;
                        sda_drv_n     = 1'b0;
                        rd_pend_n     = 1'b0;
                        rd_underrun_n = 1'b1;
                        bit_cnt_n     = '0;
                        state_n       = S_RD_DATA;
                    end else
`endif
                    if (rd_pend && rd_valid_i) begin
                        shift_n   = rd_data_i;
                        sda_drv_n = ~rd_data_i[7];
                        rd_pend_n = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_drv_n = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = S_RD_ACK;
                        end else begin
                            shift_n   = {shift[6:0], 1'b1};
                            sda_drv_n = ~shift[6];
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                // bit_cnt == 1 records a master ACK seen on this ninth clock.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (line_f[1]) state_n = S_IGNORE;
                        else           bit_cnt_n = 3'd1;
                    end else if (scl_fall && bit_cnt == 3'd1) begin
                        bit_cnt_n = '0;
                        state_n   = S_RD_LOAD;
                        rd_req_n  = 1'b1;
                        rd_pend_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef I2C_SLAVE_STRETCH_EN
        scl_drv_n = (state_n == S_RD_LOAD) || (state == S_RD_LOAD && state_n == S_RD_DATA);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            rw            <= 1'b0;
            sda_drv       <= 1'b0;
            wr_valid_o    <= 1'b0;
            wr_data_o     <= 8'h00;
            rd_req_o      <= 1'b0;
            rd_pend       <= 1'b0;
            rd_underrun_o <= 1'b0;
            bus_q         <= '0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift         <= shift_n;
            rw            <= rw_n;
            sda_drv       <= sda_drv_n;
            wr_valid_o    <= wr_valid_n;
            wr_data_o     <= wr_data_n;
            rd_req_o      <= rd_req_n;
            rd_pend       <= rd_pend_n;
            rd_underrun_o <= rd_underrun_n;
            bus_q         <= bus_n;
        end
    end

`ifdef I2C_SLAVE_STRETCH_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) scl_drv <= 1'b0;
        else          scl_drv <= scl_drv_n;
    end
    assign scl_o = scl_drv ? bus_oh : '0;
`else
    assign scl_o = '0;
`endif

    assign sda_o  = sda_drv ? bus_oh : '0;
    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder on a 4-bus build, responder on bus 2.
// Works for both the default and the I2C_SLAVE_STRETCH_EN build.
module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] m_scl = '0;
  logic [3:0] m_sda = '0;
  logic [3:0] scl_line, sda_line, scl_o, sda_o;
  logic [1:0] bus_sel = 2'd2;
  logic       busy_o, wr_valid_o, rd_req_o, rd_underrun_o;
  logic [7:0] wr_data_o;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;

  assign scl_line = ~(m_scl | scl_o);
  assign sda_line = ~(m_sda | sda_o);

  i2c_slave_responder #(.NUM_BUSSES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o),
    .bus_sel_i(bus_sel), .busy_o(busy_o),
    .wr_valid_o(wr_valid_o), .wr_data_o(wr_data_o),
    .rd_req_o(rd_req_o), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
    .rd_underrun_o(rd_underrun_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail = 0;
  int mb = 2;
  int rd_delay = 0;
  int wr_cnt = 0, unexp_cnt = 0, rd_req_cnt = 0, underrun_cnt = 0;
  int other_drive = 0, drive_cnt = 0, scl_cnt = 0, busy_gap = 0, max_stretch = 0;
  logic in_xfer = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard and event monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) unexp_cnt++;
        else check("wr_data", {24'd0, wr_data_o}, {24'd0, exp_q.pop_front()});
      end
      if (rd_req_o) rd_req_cnt++;
      if (rd_underrun_o) underrun_cnt++;
      if (|(sda_o & 4'b1011) || |(scl_o & 4'b1011)) other_drive++;
      if (sda_o[2]) drive_cnt++;
      if (scl_o[2]) scl_cnt++;
      if (in_xfer && !busy_o) busy_gap++;
    end
  end

  // read data source: answers each rd_req_o after rd_delay cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req_o) begin
        repeat (rd_delay) @(negedge clk);
        rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  end

  // master driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (!scl_line[mb] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("scl_release", {31'd0, scl_line[mb]}, 32'd1);
    if (n > max_stretch) max_stretch = n;
  endtask

  task automatic send_bit(input logic v, output logic rx);
    wait_clks(8);
    m_sda[mb] = ~v;
    wait_clks(12);
    m_scl[mb] = 1'b0;
    wait_scl_high();
    wait_clks(10);
    rx = sda_line[mb];
    wait_clks(10);
    m_scl[mb] = 1'b1;
  endtask

  task automatic i2c_start();
    m_sda[mb] = 1'b0;
    wait_clks(10);
    m_scl[mb] = 1'b0;
    wait_scl_high();
    wait_clks(15);
    m_sda[mb] = 1'b1;
    wait_clks(15);
    m_scl[mb] = 1'b1;
    wait_clks(5);
  endtask

  task automatic i2c_stop();
    m_sda[mb] = 1'b1;
    wait_clks(10);
    m_scl[mb] = 1'b0;
    wait_scl_high();
    wait_clks(15);
    m_sda[mb] = 1'b0;
    wait_clks(20);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    logic rx;
    for (int i = 7; i >= 0; i--) send_bit(d[i], rx);
    send_bit(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic rx;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, rx);
      d[i] = rx;
    end
    send_bit(nack, rx);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         base, base2;

    // reset state
    wait_clks(4);
    check("rst_scl_o", {28'd0, scl_o}, 32'd0);
    check("rst_sda_o", {28'd0, sda_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data_o}, 32'h00);
    check("rst_pulses", {29'd0, wr_valid_o, rd_req_o, rd_underrun_o}, 32'd0);
    rst_n = 1'b1;
    wait_clks(10);

    // write 0xA5, 0x3C to 0x22
    base = wr_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    i2c_start();
    check("wr_busy_start", {31'd0, busy_o}, 32'd1);
    in_xfer = 1'b1;
    write_byte(8'h44, a);  check("wr_addr_ack", {31'd0, a}, 32'd0);
    write_byte(8'hA5, a);  check("wr_b0_ack", {31'd0, a}, 32'd0);
    write_byte(8'h3C, a);  check("wr_b1_ack", {31'd0, a}, 32'd0);
    in_xfer = 1'b0;
    i2c_stop();
    check("wr_busy_stop", {31'd0, busy_o}, 32'd0);
    check("wr_count", wr_cnt - base, 32'd2);

    // wrong address: no ACK, no drive, no data
    base = wr_cnt;
    base2 = drive_cnt;
    i2c_start();
    write_byte(8'h46, a);  check("bad_addr_nack", {31'd0, a}, 32'd1);
    write_byte(8'h55, a);  check("bad_data_nack", {31'd0, a}, 32'd1);
    check("bad_no_drive", drive_cnt - base2, 32'd0);
    i2c_stop();
    check("bad_wr_count", wr_cnt - base, 32'd0);

    // read 0x96 (ACK) then 0x0F (NACK)
    base = rd_req_cnt;
    rd_delay = 2;
    rd_q.push_back(8'h96);
    rd_q.push_back(8'h0F);
    i2c_start();
    write_byte(8'h45, a);  check("rd_addr_ack", {31'd0, a}, 32'd0);
    read_byte(1'b0, d);    check("rd_byte0", {24'd0, d}, 32'h96);
    read_byte(1'b1, d);    check("rd_byte1", {24'd0, d}, 32'h0F);
    i2c_stop();
    check("rd_req_count", rd_req_cnt - base, 32'd2);

    // write 0x01, repeated START, read one byte
    base = wr_cnt;
    exp_q.push_back(8'h01);
    rd_q.push_back(8'hC3);
    i2c_start();
    in_xfer = 1'b1;
    write_byte(8'h44, a);  check("rs_wr_addr_ack", {31'd0, a}, 32'd0);
    write_byte(8'h01, a);  check("rs_wr_ack", {31'd0, a}, 32'd0);
    i2c_start();
    write_byte(8'h45, a);  check("rs_rd_addr_ack", {31'd0, a}, 32'd0);
    read_byte(1'b1, d);    check("rs_rd_byte", {24'd0, d}, 32'hC3);
    in_xfer = 1'b0;
    i2c_stop();
    check("rs_wr_count", wr_cnt - base, 32'd1);

    // read with data 200 cycles late
    base = underrun_cnt;
    rd_delay = 200;
    rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h45, a);  check("ur_addr_ack", {31'd0, a}, 32'd0);
    max_stretch = 0;
    read_byte(1'b1, d);
`ifdef I2C_SLAVE_STRETCH_EN
    check("ur_stretch_data", {24'd0, d}, 32'h5A);
    check("ur_stretch_len", {31'd0, (max_stretch >= 150)}, 32'd1);
    check("ur_no_pulse", underrun_cnt - base, 32'd0);
`else
    check("ur_data_ff", {24'd0, d}, 32'hFF);
    check("ur_pulse", underrun_cnt - base, 32'd1);
`endif
    i2c_stop();
    wait_clks(300);
    rd_delay = 0;

    // traffic on unselected bus 0 is ignored
    mb = 0;
    i2c_start();
    check("bus0_not_busy", {31'd0, busy_o}, 32'd0);
    write_byte(8'h44, a);  check("bus0_no_ack", {31'd0, a}, 32'd1);
    i2c_stop();
    mb = 2;

    // asynchronous reset while driving SDA low for a read bit
    rd_q.push_back(8'h00);
    i2c_start();
    write_byte(8'h45, a);  check("rst_addr_ack", {31'd0, a}, 32'd0);
    wait_clks(15);
    check("rst_pre_drive", {31'd0, sda_o[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_sda", {28'd0, sda_o}, 32'd0);
    check("rst_async_scl", {28'd0, scl_o}, 32'd0);
    check("rst_async_busy", {31'd0, busy_o}, 32'd0);
    wait_clks(5);
    rst_n = 1'b1;
    m_scl[2] = 1'b0;
    wait_clks(20);
    m_sda[2] = 1'b0;
    wait_clks(30);

    // end-of-run checks
    check("other_bus_drive", other_drive, 32'd0);
    check("busy_gap", busy_gap, 32'd0);
    check("wr_unexpected", unexp_cnt, 32'd0);
    check("wr_exp_left", exp_q.size(), 32'd0);
`ifdef I2C_SLAVE_STRETCH_EN
    check("scl_stretch_seen", {31'd0, (scl_cnt > 0)}, 32'd1);
`else
    check("scl_tied_low", scl_cnt, 32'd0);
    check("underrun_total", underrun_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
